pipe_ctrl: RTL

Central pipeline control unit (ctrlU) for the 4-stage core. It generates the stall/flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers, and the PC redirect. It sequences three events: EXU jump redirects with fetch-latency flush, load-use hazards, and multi-cycle EXU operations (MUL/DIV) with a timeout. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_if.sv | 44 ++++
 rtl/pipe_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the core datapath (master) and the pipeline control unit (slave).
// Carries redirect, hazard and multi-cycle inputs plus every stall/flush control back out.
interface pipe_ctrl_if #(
  parameter int ADDR_LEN = 32
);
  logic                jmp_req;
  logic [ADDR_LEN-1:0] jmp_addr;
  logic [4:0]          id_rs1_addr;
  logic [4:0]          id_rs2_addr;
  logic                id_rs1_ren;
  logic                id_rs2_ren;
  logic [4:0]          ex_wb_addr;
  logic                ex_wr_en;
  logic                ex_is_load;
  logic                exu_mc_start;
  logic                exu_mc_done;
  logic                lsu_busy;

  logic                pc_set;
  logic [ADDR_LEN-1:0] pc_new;
  logic                stall_pc;
  logic                stall_if_id;
  logic                stall_id_ex;
  logic                stall_ex_mem;
  logic                flush_if_id;
  logic                flush_id_ex;
  logic                flush_ex_mem;
  logic                mc_timeout;
  logic [31:0]         stall_cycles;

  modport master (
    output jmp_req, jmp_addr, id_rs1_addr, id_rs2_addr, id_rs1_ren, id_rs2_ren,
           ex_wb_addr, ex_wr_en, ex_is_load, exu_mc_start, exu_mc_done, lsu_busy,
    input  pc_set, pc_new, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_ex_mem, mc_timeout, stall_cycles
  );

  modport slave (
    input  jmp_req, jmp_addr, id_rs1_addr, id_rs2_addr, id_rs1_ren, id_rs2_ren,
           ex_wb_addr, ex_wr_en, ex_is_load, exu_mc_start, exu_mc_done, lsu_busy,
    output pc_set, pc_new, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_ex_mem, mc_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: jump redirect with fetch flush, load-use interlock,
// multi-cycle EXU stall with timeout, and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int ADDR_LEN     = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_MC    = 2'd2
  } state_e;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] MC_LAST_CNT  = 8'(MC_TIMEOUT - 2);
  localparam bit         HAS_FLUSH_ST = (FLUSH_CYCLES > 1);

  state_e        state_q, state_d;
  logic [2:0]    flush_cnt_q, flush_cnt_d;
  logic [7:0]    mc_cnt_q, mc_cnt_d;
  logic          mc_timeout_q, mc_timeout_d;
  logic [31:0]   stall_cycles_q, stall_cycles_d;

  logic                pc_set;
  logic [ADDR_LEN-1:0] pc_new;
  logic                stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic                flush_if_id, flush_id_ex, flush_ex_mem;

  logic [4:0] src_addr [2];
  logic [1:0] src_ren;
  logic [1:0] src_hit;
  logic       load_use;
  logic       mc_enter;

  assign src_addr[0] = bus.id_rs1_addr;
  assign src_addr[1] = bus.id_rs2_addr;
  assign src_ren     = {bus.id_rs2_ren, bus.id_rs1_ren};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = src_ren[gi] & (src_addr[gi] == bus.ex_wb_addr);
  end

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  assign load_use = bus.ex_is_load & bus.ex_wr_en & (bus.ex_wb_addr != 5'd0) & (|src_hit);
  // A start that coincides with done has already finished; it never enters MC.
  assign mc_enter = bus.exu_mc_start & ~bus.exu_mc_done;

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    mc_cnt_d     = mc_cnt_q;
    mc_timeout_d = 1'b0;
    pc_set       = 1'b0;
    pc_new       = '0;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;

    if (rst) begin
      state_d      = ST_RUN;
      flush_cnt_d  = 3'd0;
      mc_cnt_d     = 8'd0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (bus.jmp_req) begin
      pc_set      = 1'b1;
      pc_new      = bus.jmp_addr;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      mc_cnt_d    = 8'd0;
      if (HAS_FLUSH_ST) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FLUSH_RELOAD;
      end else begin
        state_d     = ST_RUN;
        flush_cnt_d = 3'd0;
      end
    end else if ((state_q == ST_MC) && !bus.exu_mc_done) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      if (mc_cnt_q == MC_LAST_CNT) begin
        state_d      = ST_RUN;
        mc_cnt_d     = 8'd0;
        mc_timeout_d = 1'b1;
      end else begin
        mc_cnt_d = mc_cnt_q + 8'd1;
      end
    end else if ((state_q != ST_MC) && mc_enter) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      state_d      = ST_MC;
      mc_cnt_d     = 8'd0;
      flush_cnt_d  = 3'd0;
    end else begin
      // Released MC (done seen) behaves like RUN for the rest of this cycle.
      if (state_q == ST_MC) begin
        state_d  = ST_RUN;
        mc_cnt_d = 8'd0;
      end else if (state_q == ST_FLUSH) begin
        flush_if_id = 1'b1;
        if (flush_cnt_q <= 3'd1) begin
          state_d     = ST_RUN;
          flush_cnt_d = 3'd0;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end

      if (bus.lsu_busy) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
      end else if (load_use) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_pc && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      flush_cnt_q    <= 3'd0;
      mc_cnt_q       <= 8'd0;
      mc_timeout_q   <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      mc_cnt_q       <= mc_cnt_d;
      mc_timeout_q   <= mc_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.pc_set       = pc_set;
  assign bus.pc_new       = pc_new;
  assign bus.stall_pc     = stall_pc;
  assign bus.stall_if_id  = stall_if_id;
  assign bus.stall_id_ex  = stall_id_ex;
  assign bus.stall_ex_mem = stall_ex_mem;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.flush_id_ex  = flush_id_ex;
  assign bus.flush_ex_mem = flush_ex_mem;
  assign bus.mc_timeout   = mc_timeout_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule
